// File: rtl/cpu_pkg.sv
// Shared constants and the fetch-queue entry type for the MIPS front end.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; holds fetched {inst, pc} entries for decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Flush wins over a same-cycle push: that word belongs to the old path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, response queue, redirects.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_dropped counters.
module fetch_unit #(
  parameter int                XLEN       = cpu_pkg::XLEN,
  parameter int                DEPTH      = 4,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'(cpu_pkg::RESET_PC),
  parameter logic [XLEN-1:0]   EXC_VECTOR = XLEN'(cpu_pkg::EXC_VECTOR)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             exception,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_inst,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_next_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_dropped
`endif
);

  import cpu_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Handshakes: imem request transfers when imem_req & imem_gnt at a rising edge;
  // decode transfer happens when id_valid & id_ready at a rising edge.
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   outstanding_next;
  logic [CW:0]     inflight;
  logic            redir;
  logic [XLEN-1:0] target;
  logic            grant;
  logic            accept;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;
  logic            q_empty;
  logic            q_full;
  logic [CW-1:0]   q_count;

  assign redir    = redirect_valid || exception;
  assign target   = exception ? EXC_VECTOR : redirect_pc;
  // Outstanding requests reserve a queue slot, so the queue can never overflow.
  assign inflight = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req = reset && (inflight < (CW+1)'(DEPTH)) && !redir;
  assign imem_addr = fetch_pc;
  assign grant    = imem_req && imem_gnt;
  assign accept   = imem_rvalid && (drop == '0);
  assign pop      = id_valid && id_ready;
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);

  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = resp_pc;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redir),
    .head      (head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  assign id_valid   = !q_empty;
  assign id_inst    = q_empty ? '0 : head.inst;
  assign id_pc      = q_empty ? '0 : head.pc;
  assign id_next_pc = q_empty ? '0 : head.pc + XLEN'(4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redir) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= outstanding_next;
      end else begin
        if (grant)  fetch_pc <= fetch_pc + XLEN'(4);
        if (accept) resp_pc  <= resp_pc + XLEN'(4);
        if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic fetched_evt;
  logic dropped_evt;

  // A word arriving in a redirect cycle is flushed, so it counts as dropped.
  assign fetched_evt = accept && !redir;
  assign dropped_evt = imem_rvalid && !fetched_evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (fetched_evt && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (dropped_evt && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

  a_rvalid_has_credit: assert property (@(posedge clock) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(accept && q_full));

  a_addr_hold: assert property (@(posedge clock) disable iff (!reset)
    (imem_req && !imem_gnt) |=> (redirect_valid || exception || (imem_req && $stable(imem_addr))));

endmodule
